// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver: deserialises 11-bit frames, tracks make/break, presents held key as HID code.
// Latency: keycode/key_valid update on the 3rd Clk rising edge after the ps2_clk pin falls for the stop bit.
// Backpressure: none; key_valid/frame_err are single-cycle pulses. Optional parity check: PS2_PARITY_CHECK_EN.
module ps2_keycode_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } dec_state_t;

  // Synchroniser chains: index 0 = s1, 1 = s2, 2 = s3.
  logic [2:0] clk_sync;
  logic [2:0] dat_sync;
  logic       fall;
  logic       sample;

  // Frame assembly state.
  logic [3:0]        bit_cnt;
  logic [9:0]        shreg;      // [0]=start, [8:1]=D0..D7, [9]=parity
  logic [IDLE_W-1:0] idle_cnt;

  logic [7:0] rx_byte;
  logic       frame_done;
  logic       frame_ok;
  logic       parity_odd;
  logic       timeout;
  logic       byte_ok;
  logic       frame_err_nxt;

  // Decode state.
  dec_state_t state;
  dec_state_t state_nxt;
  logic [7:0] keycode_nxt;
  logic       key_valid_nxt;
  logic [7:0] mapped;

  // Set-2 make code to HID usage; 8'h00 means "not a key we care about".
  function automatic logic [7:0] map_key(input logic [7:0] b);
    case (b)
      8'h29:   return 8'h2C;  // SPACE
      8'h5A:   return 8'h28;  // ENTER
      8'h2D:   return 8'h15;  // R
      8'h76:   return 8'h29;  // ESC
      8'h1D:   return 8'h1A;  // W
      8'h1B:   return 8'h16;  // S
      default: return 8'h00;
    endcase
  endfunction

  // Bring the asynchronous PS/2 pins into the Clk domain through three flops each.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_sync <= 3'b000;
      dat_sync <= 3'b000;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[1:0], ps2_data};
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign sample = dat_sync[1];

  assign rx_byte    = shreg[8:1];
  assign parity_odd = ^shreg[9:1];
  assign frame_done = fall && (bit_cnt == 4'd10);

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = ~shreg[0] & sample & parity_odd;
`else
  // Parity is still shifted in so the frame layout is identical; it is just not judged.
  logic unused_parity;
  assign unused_parity = parity_odd;
  assign frame_ok      = ~shreg[0] & sample;
`endif

  // A stalled partial frame is abandoned; a fall in the same cycle takes priority.
  assign timeout       = (bit_cnt != 4'd0) && !fall && (idle_cnt >= IDLE_LAST);
  assign byte_ok       = frame_done && frame_ok;
  assign frame_err_nxt = (frame_done && !frame_ok) || timeout;

  // Shift in one bit per ps2_clk falling edge and watch for a stalled frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bit_cnt  <= 4'd0;
      shreg    <= 10'd0;
      idle_cnt <= '0;
    end else if (fall) begin
      idle_cnt <= '0;
      if (bit_cnt == 4'd10) begin
        bit_cnt <= 4'd0;
      end else begin
        shreg[bit_cnt] <= sample;
        bit_cnt        <= bit_cnt + 4'd1;
      end
    end else if (timeout) begin
      bit_cnt  <= 4'd0;
      idle_cnt <= '0;
    end else if (bit_cnt != 4'd0) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end

  // Make/break/extended decode of each accepted byte; decides the next held key.
  always_comb begin
    state_nxt     = state;
    keycode_nxt   = keycode;
    key_valid_nxt = 1'b0;
    mapped        = map_key(rx_byte);
    if (byte_ok) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == 8'hF0) begin
            state_nxt = ST_BRK;
          end else if (rx_byte == 8'hE0) begin
            state_nxt = ST_EXT;
          end else if (mapped != 8'h00 && mapped != keycode) begin
            // Last pressed wins; typematic repeats of the held key are silent.
            keycode_nxt   = mapped;
            key_valid_nxt = 1'b1;
          end
        end
        ST_BRK: begin
          // Only releasing the currently shown key clears it.
          if (mapped == keycode && keycode != 8'h00) begin
            keycode_nxt   = 8'h00;
            key_valid_nxt = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
        ST_EXT: begin
          state_nxt = (rx_byte == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Register decode state and the output pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      keycode   <= 8'h00;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      keycode   <= keycode_nxt;
      key_valid <= key_valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: drives PS/2 frames on the pins and checks keycode/pulses.
// Uses a short timeout parameter so the stalled-frame case stays quick.
// Expected values are hand-derived from the scan-code map and frame format.
module tb_ps2_keycode_rx;

  localparam int TMO = 400;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  int n_checks = 0;
  int n_fail = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int kv_base;
  int fe_base;

  ps2_keycode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .keycode(keycode),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Sends the first nbits of a frame; lat=1 checks pulse timing around the stop-bit fall.
  task automatic send_frame(input logic [10:0] bits, input int nbits, input bit lat);
    for (int i = 0; i < nbits; i++) begin
      @(negedge Clk);
      ps2_data = bits[i];
      repeat (4) @(negedge Clk);
      ps2_clk = 1'b0;
      if (lat && i == 10) begin
        @(posedge Clk); #1;
        check("lat_edge1_vld", key_valid, 0);
        @(posedge Clk); #1;
        check("lat_edge2_vld", key_valid, 0);
        check("lat_edge2_key", keycode, 8'h00);
        @(posedge Clk); #1;
        check("lat_edge3_vld", key_valid, 1);
        check("lat_edge3_key", keycode, 8'h2C);
      end
      repeat (8) @(negedge Clk);
      ps2_clk = 1'b1;
      repeat (3) @(negedge Clk);
    end
    ps2_data = 1'b1;
    repeat (6) @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(mk(b, 1'b0, 1'b0), 11, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    check("rst_keycode", keycode, 8'h00);
    check("rst_key_valid", key_valid, 0);
    check("rst_frame_err", frame_err, 0);

    // Press and release SPACE, with exact latency on the make.
    kv_base = kv_cnt;
    send_frame(mk(8'h29, 1'b0, 1'b0), 11, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h29);
    check("space_release_key", keycode, 8'h00);
    check("space_kv_pulses", kv_cnt - kv_base, 2);

    // Typematic repeat.
    kv_base = kv_cnt;
    send_byte(8'h29);
    send_byte(8'h29);
    send_byte(8'h29);
    check("typematic_key", keycode, 8'h2C);
    check("typematic_kv", kv_cnt - kv_base, 1);
    send_byte(8'hF0);
    send_byte(8'h29);

    // Last pressed wins; releasing the older key has no effect.
    kv_base = kv_cnt;
    send_byte(8'h29);
    send_byte(8'h5A);
    check("overwrite_key", keycode, 8'h28);
    send_byte(8'hF0);
    send_byte(8'h29);
    check("stale_release_key", keycode, 8'h28);
    check("overwrite_kv", kv_cnt - kv_base, 2);
    send_byte(8'hF0);
    send_byte(8'h5A);
    check("enter_release_key", keycode, 8'h00);

    // Extended make/break ignored.
    kv_base = kv_cnt;
    send_byte(8'hE0);
    send_byte(8'h29);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h29);
    check("ext_key", keycode, 8'h00);
    check("ext_kv", kv_cnt - kv_base, 0);
    send_byte(8'h5A);
    check("after_ext_key", keycode, 8'h28);
    send_byte(8'hF0);
    send_byte(8'h5A);

    // Bad stop bit.
    kv_base = kv_cnt;
    fe_base = fe_cnt;
    send_frame(mk(8'h29, 1'b0, 1'b1), 11, 1'b0);
    check("bad_stop_fe", fe_cnt - fe_base, 1);
    check("bad_stop_key", keycode, 8'h00);
    check("bad_stop_kv", kv_cnt - kv_base, 0);

    // Wrong parity.
    fe_base = fe_cnt;
    send_frame(mk(8'h29, 1'b1, 1'b0), 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("bad_par_fe", fe_cnt - fe_base, 1);
    check("bad_par_key", keycode, 8'h00);
`else
    check("bad_par_fe", fe_cnt - fe_base, 0);
    check("bad_par_key", keycode, 8'h2C);
    send_byte(8'hF0);
    send_byte(8'h29);
`endif

    // Stalled partial frame.
    fe_base = fe_cnt;
    send_frame(mk(8'h76, 1'b0, 1'b0), 5, 1'b0);
    repeat (TMO + 50) @(negedge Clk);
    check("timeout_fe", fe_cnt - fe_base, 1);
    repeat (2 * TMO) @(negedge Clk);
    check("timeout_fe_once", fe_cnt - fe_base, 1);
    send_byte(8'h76);
    check("after_timeout_key", keycode, 8'h29);

    // Reset in the middle of a frame.
    fe_base = fe_cnt;
    send_frame(mk(8'h1D, 1'b0, 1'b0), 4, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("midrst_keycode", keycode, 8'h00);
    check("midrst_key_valid", key_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_no_fe", fe_cnt - fe_base, 0);
    send_byte(8'h5A);
    check("after_midrst_key", keycode, 8'h28);

    check("vld_err_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
